// File: rtl/sdram_protocol_monitor.sv
// Passive SDRAM command-bus monitor: decodes each command, tracks per-bank state
// and timing, and reports protocol violations one cycle after the command.
module sdram_protocol_monitor #(
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_BITS  = 2,
  parameter int DQM_WIDTH  = 2,
  parameter int T_RCD      = 3,
  parameter int T_RP       = 3,
  parameter int T_RC       = 9,
  parameter int T_MRD      = 2,
  parameter int T_REF_MAX  = 781
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   zs_addr,
  input  logic [BANK_BITS-1:0]    zs_ba,
  input  logic                    zs_cs_n,
  input  logic                    zs_ras_n,
  input  logic                    zs_cas_n,
  input  logic                    zs_we_n,
  input  logic                    zs_cke,
  input  logic [DQM_WIDTH-1:0]    zs_dqm,
  output logic                    cmd_valid,
  output logic [2:0]              cmd_code,
  output logic                    error_valid,
  output logic [7:0]              error_code,
  output logic [7:0]              error_sticky,
  output logic [15:0]             error_count,
  output logic [15:0]             refresh_count,
  output logic [2**BANK_BITS-1:0] bank_open,
  output logic [ADDR_WIDTH-1:0]   mode_reg,
  output logic                    mode_valid
);

  localparam int NBANKS = 2**BANK_BITS;
  localparam int TW     = $clog2(T_RCD + T_RP + T_RC + T_MRD + 2);
  localparam int RW     = $clog2(T_REF_MAX + 1);

  localparam logic [TW-1:0] TMAX     = '1;
  localparam logic [TW-1:0] TONE     = TW'(1);
  localparam logic [TW-1:0] LIM_RCD  = TW'(T_RCD);
  localparam logic [TW-1:0] LIM_RP   = TW'(T_RP);
  localparam logic [TW-1:0] LIM_RC   = TW'(T_RC);
  localparam logic [TW-1:0] LIM_MRD  = TW'(T_MRD);
  localparam logic [RW-1:0] REF_LAST = RW'(T_REF_MAX - 1);

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_LMR, CMD_BST
  } cmd_e;

  cmd_e                  cmd;
  logic [7:0]            err;
  logic                  expire;
  logic                  unusedDqm;

  logic [NBANKS-1:0]     bankOpen_q, bankOpen_d;
  logic [TW-1:0]         tAct_q [NBANKS];
  logic [TW-1:0]         tAct_d [NBANKS];
  logic [TW-1:0]         tPre_q [NBANKS];
  logic [TW-1:0]         tPre_d [NBANKS];
  logic [TW-1:0]         tMrd_q, tMrd_d;
  logic                  refArmed_q, refArmed_d;
  logic [RW-1:0]         refCnt_q, refCnt_d;
  logic [ADDR_WIDTH-1:0] modeReg_q, modeReg_d;
  logic                  modeValid_q, modeValid_d;
  logic [7:0]            sticky_q, sticky_d;
  logic [15:0]           errCount_q, errCount_d;
  logic [15:0]           refCount_q, refCount_d;
  cmd_e                  cmdCode_q;
  logic                  cmdValid_q, errValid_q;
  logic [7:0]            errCode_q;

  assign unusedDqm = ^zs_dqm;

  always_comb begin
    cmd = CMD_NOP;
    if (zs_cke && !zs_cs_n) begin
      case ({zs_ras_n, zs_cas_n, zs_we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_READ;
        3'b100:  cmd = CMD_WRITE;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_LMR;
        3'b110:  cmd = CMD_BST;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  // Timers hold "edges since event" and are loaded with 1 on the event edge.
  always_comb begin
    bankOpen_d  = bankOpen_q;
    for (int b = 0; b < NBANKS; b++) begin
      tAct_d[b] = (tAct_q[b] == TMAX) ? tAct_q[b] : tAct_q[b] + TONE;
      tPre_d[b] = (tPre_q[b] == TMAX) ? tPre_q[b] : tPre_q[b] + TONE;
    end
    tMrd_d      = (tMrd_q == TMAX) ? tMrd_q : tMrd_q + TONE;
    refArmed_d  = refArmed_q;
    refCnt_d    = refCnt_q;
    expire      = 1'b0;
    modeReg_d   = modeReg_q;
    modeValid_d = modeValid_q;
    err         = '0;

    if (refArmed_q) begin
      if (refCnt_q == REF_LAST) begin
        refCnt_d = '0;
        expire   = (cmd != CMD_REF);
      end else begin
        refCnt_d = refCnt_q + RW'(1);
      end
    end

    if (cmd != CMD_NOP && tMrd_q < LIM_MRD) err[6] = 1'b1;

    case (cmd)
      CMD_ACT: begin
        err[1]             = bankOpen_q[zs_ba];
        err[3]             = tPre_q[zs_ba] < LIM_RP;
        err[4]             = tAct_q[zs_ba] < LIM_RC;
        bankOpen_d[zs_ba]  = 1'b1;
        tAct_d[zs_ba]      = TONE;
      end
      CMD_READ, CMD_WRITE: begin
        err[0] = !bankOpen_q[zs_ba];
        err[2] = tAct_q[zs_ba] < LIM_RCD;
      end
      CMD_PRE: begin
        if (zs_addr[10]) begin
          bankOpen_d = '0;
          for (int b = 0; b < NBANKS; b++) tPre_d[b] = TONE;
        end else begin
          bankOpen_d[zs_ba] = 1'b0;
          tPre_d[zs_ba]     = TONE;
        end
      end
      CMD_REF: begin
        err[5]     = |bankOpen_q;
        refArmed_d = 1'b1;
        refCnt_d   = '0;
      end
      CMD_LMR: begin
        err[5]      = |bankOpen_q;
        modeReg_d   = zs_addr;
        modeValid_d = 1'b1;
        tMrd_d      = TONE;
      end
      default: ;
    endcase

    err[7]     = expire;
    sticky_d   = sticky_q | err;
    errCount_d = (|err && errCount_q != 16'hFFFF) ? errCount_q + 16'd1 : errCount_q;
    refCount_d = (cmd == CMD_REF && refCount_q != 16'hFFFF) ? refCount_q + 16'd1 : refCount_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bankOpen_q  <= '0;
      for (int b = 0; b < NBANKS; b++) begin
        tAct_q[b] <= TMAX;
        tPre_q[b] <= TMAX;
      end
      tMrd_q      <= TMAX;
      refArmed_q  <= 1'b0;
      refCnt_q    <= '0;
      modeReg_q   <= '0;
      modeValid_q <= 1'b0;
      sticky_q    <= '0;
      errCount_q  <= '0;
      refCount_q  <= '0;
      cmdValid_q  <= 1'b0;
      cmdCode_q   <= CMD_NOP;
      errValid_q  <= 1'b0;
      errCode_q   <= '0;
    end else begin
      bankOpen_q  <= bankOpen_d;
      for (int b = 0; b < NBANKS; b++) begin
        tAct_q[b] <= tAct_d[b];
        tPre_q[b] <= tPre_d[b];
      end
      tMrd_q      <= tMrd_d;
      refArmed_q  <= refArmed_d;
      refCnt_q    <= refCnt_d;
      modeReg_q   <= modeReg_d;
      modeValid_q <= modeValid_d;
      sticky_q    <= sticky_d;
      errCount_q  <= errCount_d;
      refCount_q  <= refCount_d;
      cmdValid_q  <= (cmd != CMD_NOP);
      cmdCode_q   <= cmd;
      errValid_q  <= |err;
      errCode_q   <= err;
    end
  end

  assign cmd_valid     = cmdValid_q;
  assign cmd_code      = cmdCode_q;
  assign error_valid   = errValid_q;
  assign error_code    = errCode_q;
  assign error_sticky  = sticky_q;
  assign error_count   = errCount_q;
  assign refresh_count = refCount_q;
  assign bank_open     = bankOpen_q;
  assign mode_reg      = modeReg_q;
  assign mode_valid    = modeValid_q;

endmodule
